shreg_sched: RTL

Two-requester scheduler for a shared 4-bit holding/shift register. Arbitrates between two clients with round-robin priority, parallel-loads the winner's word into the register, then sequences it out serially MSB-first with a valid strobe and a completion pulse. Sits between client logic and the serial link, owning the register's load/shift control.

---
 rtl/shreg_pkg.sv | 13 +
 rtl/shreg_sched_rr_arb2.sv | 18 +
 rtl/shreg_sched.sv | 100 ++++++++++
 3 files changed

// File: rtl/shreg_pkg.sv
// Shared types and constants for the two-client shift-register scheduler.
package shreg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int SHREG_WIDTH_DEFAULT = 4;
   localparam int N_CLIENTS           = 2;

endpackage

// File: rtl/shreg_sched_rr_arb2.sv
// Two-client round-robin arbiter: on a tie the client that did not win last time wins.
module rr_arb2
   import shreg_pkg::*;
(
   input  logic [N_CLIENTS-1:0] req,
   input  logic                 last,
   output logic [N_CLIENTS-1:0] win
);

   // NOTE: give every combinational output a default first so no path leaves it unassigned (no latch).
   always_comb begin
      win = req;
      if (req == 2'b11) begin
         win = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/shreg_sched.sv
// Arbitrates two clients, parallel-loads the winner's word and shifts it out MSB-first.
module shreg_sched
   import shreg_pkg::*;
#(
   parameter int WIDTH = SHREG_WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [N_CLIENTS-1:0] req,
   input  logic [WIDTH-1:0]     din0,
   input  logic [WIDTH-1:0]     din1,
   output logic [N_CLIENTS-1:0] grant,
   output logic                 busy,
   output logic                 serial_out,
   output logic                 serial_valid,
   output logic                 done,
   output logic [WIDTH-1:0]     parallel_out
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t                 state;
   state_t                 state_nxt;
   logic [WIDTH-1:0]       sreg;
   logic [CW-1:0]          count;
   logic                   last;
   logic [N_CLIENTS-1:0]   win;

   rr_arb2 u_arb (
      .req  (req),
      .last (last),
      .win  (win)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (req != '0) state_nxt = SHIFT;
            SHIFT:   if (count == LAST_BIT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      busy         = (state != IDLE);
      serial_valid = (state == SHIFT);
      done         = (state == DONE);
      serial_out   = sreg[WIDTH-1];
      parallel_out = sreg;
   end

   // Holding register, bit counter, grant pulse and last-winner pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg  <= '0;
         count <= '0;
         grant <= '0;
         last  <= 1'b1;
      end else begin
         grant <= '0;
         if (flush) begin
            sreg  <= '0;
            count <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (win != '0) begin
                     sreg  <= win[1] ? din1 : din0;
                     count <= '0;
                     grant <= win;
                     last  <= win[1];
                  end
               end
               SHIFT: begin
                  sreg  <= {sreg[WIDTH-2:0], 1'b0};
                  count <= (count == LAST_BIT) ? '0 : count + CW'(1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule
